// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: UART transmit serializer draining the show-ahead read
// port of the TX async FIFO in the rclk domain.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit after the data).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for tx_en and a non-empty FIFO
// START  | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA   | data bits, LSB first, one per CLKS_PER_BIT cycles
// PARITY | parity bit from the latched word (UART_TX_PARITY_EN only)
// STOP   | stop bit(s); the last cycle may pop the next word directly
module uart_tx_fifo_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  tx_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  fifo_rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    // Elaboration-time parameter sanity checks
    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
        $error("PARITY_ODD must be 0 or 1");
    end
    if (DATA_WIDTH < 1) begin : g_chk_dw
        $error("DATA_WIDTH must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  tx_n;
    logic                  wrap;
    logic                  can_pop;

    assign wrap    = (cnt == CNT_LAST);
    // Reset also masks the pop so the FIFO is never drained while held in reset
    assign can_pop = tx_en & ~fifo_rempty & rrst_n;

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Parity is taken from the word as it is popped, not from the shifting copy
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            parity_q <= 1'b0;
        else if (fifo_rinc)
            parity_q <= (^fifo_rdata) ^ (PARITY_ODD != 0);
    end
`endif

    // Next-state, counters, shift register, pop and frame-done strobes
    always_comb begin
        state_n    = state;
        cnt_n      = wrap ? '0 : cnt + 1'b1;
        idx_n      = idx;
        shreg_n    = shreg;
        fifo_rinc  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (can_pop) begin
                    fifo_rinc = 1'b1;
                    shreg_n   = fifo_rdata;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (wrap)
                    state_n = ST_DATA;
            end
            ST_DATA: begin
                if (wrap) begin
                    shreg_n = shreg >> 1;
                    if (idx == DATA_LAST) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (wrap)
                    state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (wrap) begin
                    if (idx == STOP_LAST) begin
                        frame_done = 1'b1;
                        idx_n      = '0;
                        if (can_pop) begin
                            fifo_rinc = 1'b1;
                            shreg_n   = fifo_rdata;
                            state_n   = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Line level for the coming cycle, so tx can be a plain flop
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = parity_q;
`endif
            default:   tx_n = 1'b1;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx    <= tx_n;
            busy  <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader with default parameters.
// With UART_TX_PARITY_EN defined the frame grows by one parity bit.
module tb_uart_tx_fifo_reader #(
    parameter int PODD = 0
);
    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       tx_en;
    logic [7:0] fifo_rdata;
    logic       fifo_rempty;
    logic       fifo_rinc;
    logic       tx;
    logic       busy;
    logic       frame_done;

    uart_tx_fifo_reader #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1),
        .PARITY_ODD  (PODD)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .tx_en      (tx_en),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc  (fifo_rinc),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 rclk = ~rclk;

    // Show-ahead FIFO model: head advanced by the DUT's pop, tail by the bench
    logic [7:0] mem [0:15];
    int head = 0;
    int tail = 0;
    int pops = 0;
    logic pop_empty = 1'b0;
    logic pop_dbl   = 1'b0;
    logic rinc_d    = 1'b0;

    assign fifo_rempty = (head == tail);
    assign fifo_rdata  = mem[head[3:0]];

    always @(posedge rclk) begin
        if (fifo_rinc) begin
            if (fifo_rempty) pop_empty <= 1'b1;
            if (rinc_d)      pop_dbl   <= 1'b1;
            head <= head + 1;
            pops <= pops + 1;
        end
        rinc_d <= fifo_rinc;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[tail[3:0]] = d;
        tail++;
    endtask

    // Leaves the bench at the negedge of the pop cycle (or checks the current cycle first)
    task automatic wait_pop(input int lim, input string name);
        logic found;
        #1;
        found = fifo_rinc;
        for (int i = 0; i < lim && !found; i++) begin
            @(negedge rclk);
            found = fifo_rinc;
        end
        chk(name, {31'd0, found}, 32'd1);
    endtask

    // Called in the pop cycle; samples mid-bit and checks frame_done at pop+FL
    task automatic check_frame(input string name, input logic [9:0] bits, input logic par);
        logic e;
        for (int k = 0; k < NB; k++) begin
            if (k == 0) repeat (8) @(negedge rclk);
            else        repeat (CPB) @(negedge rclk);
            if (NB == 11 && k == 9)       e = par ^ PODD[0];
            else if (NB == 11 && k == 10) e = bits[9];
            else                          e = bits[k];
            chk($sformatf("%s_bit%0d", name, k), {31'd0, tx}, {31'd0, e});
        end
        repeat (7) @(negedge rclk);
        chk({name, "_fd_early"}, {31'd0, frame_done}, 32'd0);
        chk({name, "_busy_mid"}, {31'd0, busy}, 32'd1);
        @(negedge rclk);
        chk({name, "_fd"}, {31'd0, frame_done}, 32'd1);
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // tx sample order: [0]=start, [8:1]=data, [9]=stop
        logic       par;    // even parity of data
    } vec_t;

    vec_t vecs [6];

    initial begin
        int viol;
        int p0;

        vecs[0] = '{8'hA5, 10'h34A, 1'b0};
        vecs[1] = '{8'h01, 10'h202, 1'b1};
        vecs[2] = '{8'h80, 10'h300, 1'b1};
        vecs[3] = '{8'h3C, 10'h278, 1'b0};
        vecs[4] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[5] = '{8'h00, 10'h200, 1'b0};

        rrst_n = 1'b0;
        tx_en  = 1'b0;
        repeat (3) @(negedge rclk);
        chk("rst_tx",   {31'd0, tx},         32'd1);
        chk("rst_busy", {31'd0, busy},       32'd0);
        chk("rst_rinc", {31'd0, fifo_rinc},  32'd0);
        chk("rst_fd",   {31'd0, frame_done}, 32'd0);
        rrst_n = 1'b1;

        // Enabled but empty
        tx_en = 1'b1;
        viol  = 0;
        repeat (500) begin
            @(negedge rclk);
            if (fifo_rinc || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("empty_idle", viol, 0);

        // Data available but disabled
        tx_en = 1'b0;
        push(8'h11);
        viol = 0;
        repeat (200) begin
            @(negedge rclk);
            if (fifo_rinc || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("disabled_idle", viol, 0);
        chk("disabled_pops", pops, 0);
        tail = head;

        // Single frames from the vector table
        tx_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].data);
            wait_pop(20, $sformatf("v%0d_pop", i));
            check_frame($sformatf("v%0d", i), vecs[i].bits, vecs[i].par);
            @(negedge rclk);
            chk($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_tx_after", i),   {31'd0, tx},   32'd1);
        end

        // Back-to-back frames: second pop on the first frame_done
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        wait_pop(20, "b2b_pop0");
        check_frame("b2b0", 10'h200, 1'b0);
        chk("b2b_pop_at_done", {31'd0, fifo_rinc}, 32'd1);
        check_frame("b2b1", 10'h3FE, 1'b0);
        @(negedge rclk);
        chk("b2b_busy_after", {31'd0, busy}, 32'd0);
        repeat (50) @(negedge rclk);
        chk("b2b_pops", pops - p0, 2);
        chk("b2b_tx_idle", {31'd0, tx}, 32'd1);

        // tx_en dropped mid-frame with a second word waiting
        push(8'h3C);
        push(8'hC3);
        wait_pop(20, "drop_pop");
        p0 = pops;
        repeat (40) @(negedge rclk);
        tx_en = 1'b0;
        repeat (FL - 41) @(negedge rclk);
        chk("drop_fd_early", {31'd0, frame_done}, 32'd0);
        @(negedge rclk);
        chk("drop_fd",   {31'd0, frame_done}, 32'd1);
        chk("drop_rinc", {31'd0, fifo_rinc},  32'd0);
        repeat (300) @(negedge rclk);
        chk("drop_no_pop", pops, p0 + 1);
        chk("drop_busy",   {31'd0, busy}, 32'd0);

        // Reset mid-frame: 0xC3 is popped then aborted, 0x5A must follow
        push(8'h5A);
        tx_en = 1'b1;
        wait_pop(20, "rst_pop");
        repeat (50) @(negedge rclk);
        chk("pre_rst_tx", {31'd0, tx}, 32'd0);
        rrst_n = 1'b0;
        #1;
        chk("midrst_tx",   {31'd0, tx},        32'd1);
        chk("midrst_busy", {31'd0, busy},      32'd0);
        chk("midrst_rinc", {31'd0, fifo_rinc}, 32'd0);
        repeat (3) @(negedge rclk);
        rrst_n = 1'b1;
        wait_pop(20, "after_rst_pop");
        check_frame("after_rst", 10'h2B4, 1'b0);
        @(negedge rclk);
        chk("after_rst_busy", {31'd0, busy}, 32'd0);

`ifdef UART_TX_PARITY_EN
        push(8'h07);
        wait_pop(20, "par_pop");
        check_frame("par07", 10'h20E, 1'b1);
        @(negedge rclk);
`endif

        chk("no_pop_when_empty", {31'd0, pop_empty}, 32'd0);
        chk("no_double_pop",     {31'd0, pop_dbl},   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
UART transmit serializer that drains the read end of the TX async FIFO in its read clock domain. When the FIFO is non-empty and transmission is enabled, it pops one word and shifts it out on the serial line. Frame format is start bit, data LSB first, optional parity, then stop bit(s). It connects directly to the FIFO's show-ahead read port (rdata valid whenever rempty=0; rinc pops).

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the FIFO DATA_WIDTH
CLKS_PER_BIT, 16, rclk cycles per serial bit; legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY_ODD, 0, parity sense when parity is compiled in; 0 = even, 1 = odd

Ports:
rclk  input  1  clock (FIFO read domain)
rrst_n  input  1  asynchronous active-low reset
tx_en  input  1  permits starting new frames
fifo_rdata  input  DATA_WIDTH  FIFO head word, show-ahead
fifo_rempty  input  1  FIFO empty flag
fifo_rinc  output  1  pop strobe to FIFO, one cycle per frame
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset is asynchronous, active-low. Output reset values: tx=1, busy=0, fifo_rinc=0, frame_done=0. Internal reset state: state=IDLE, baud counter=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - tx=1.
  - If tx_en=1 and fifo_rempty=0 in cycle T: fifo_rinc=1 in cycle T only; fifo_rdata is latched into the shift register; next state is START.
- Bit timing:
  - Every bit is held on tx for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
  - The counter restarts at 0 on every state or bit change.
- Start bit: tx=0 from cycle T+1 through T+CLKS_PER_BIT.
- DATA: DATA_WIDTH bits, LSB first. The bit index is incremented when the counter wraps. DATA exits after index DATA_WIDTH-1.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle.
  - If tx_en=1 and fifo_rempty=0 on that final cycle, the next word is popped (fifo_rinc=1) in the same cycle and the next state is START. This gives zero idle gap between frames; otherwise the next state is IDLE.
- Frame length: from the pop cycle to the next possible pop cycle is exactly (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity compiled in, else 0.
- busy:
  - busy=1 from T+1 through the last stop-bit cycle.
  - busy stays 1 across back-to-back frames.
  - busy=0 in IDLE.
- Pop rules:
  - fifo_rinc is never asserted while fifo_rempty=1.
  - fifo_rinc is never asserted outside IDLE or the final STOP cycle.
  - fifo_rinc is never high for two consecutive cycles unless CLKS_PER_BIT... not applicable: minimum spacing is one full frame.
- tx_en deasserted mid-frame: the current frame completes unchanged, and no further pop occurs.
- fifo_rempty or fifo_rdata changing mid-frame: no effect, because the data is latched at pop.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous). The popped word is discarded and is not re-transmitted.
- tx is driven from a flop; there are no combinational paths from inputs to tx.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and lasts CLKS_PER_BIT cycles.
  - Even sense (PARITY_ODD=0): tx = XOR of the data bits.
  - Odd sense (PARITY_ODD=1): tx = its inverse.
  - Parity is computed from the latched word.
- Undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP. PARITY_ODD is ignored.

Test Plan:
- Single byte, default parameters, macro undefined:
  - Stimulus: FIFO holds 0xA5, tx_en=1.
  - Response: exactly one fifo_rinc pulse. Mid-bit samples of tx (cycle 8 of each bit) read 0,1,0,1,0,0,1,0,1,1. frame_done pulses at pop+160, then busy=0.
- Back-to-back frames:
  - Stimulus: FIFO holds 0x00 then 0xFF.
  - Response: second pop coincides with the first frame_done. tx shows no idle cycle between frames. 320 cycles total, exactly 2 pops, then the line idles high.
- Empty and disabled cases:
  - Stimulus: fifo_rempty=1 for 500 cycles; separately, a non-empty FIFO with tx_en=0.
  - Response: fifo_rinc never asserts, tx=1 and busy=0 throughout.
- tx_en dropped mid-frame:
  - Stimulus: tx_en drops at pop+40 with 2 words queued.
  - Response: the first frame completes to frame_done at pop+160, and no second pop occurs.
- Reset mid-frame:
  - Stimulus: rrst_n pulsed low at pop+50 for 3 cycles.
  - Response: tx=1 and busy=0 within the reset cycle. After release, the next queued word is popped and the aborted byte is not resent.
- Parity, UART_TX_PARITY_EN defined:
  - Even sense: byte 0x07 gives a parity bit of 1 and frame_done at pop+176.
  - Odd sense (PARITY_ODD=1): byte 0x07 gives a parity bit of 0.
